// File: rtl/mask_index_encoder.sv
// Sequential scanning priority encoder: walks a wide mask and emits the binary
// index of each set bit, lowest first, one per valid/ready handshake.
module mask_index_encoder #(
  parameter int IDX_W = 7,
  parameter int N     = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [N-1:0]     mask_in,
  input  logic             clear,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   count
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [N-1:0]     pending;
  logic [N-1:0]     pending_nxt;
  logic [IDX_W-1:0] low_idx;

  // Descending walk so the lowest set bit is the last (winning) assignment.
  always_comb begin
    low_idx = '0;
    for (int i = N-1; i >= 0; i--)
      if (pending[i]) low_idx = IDX_W'(i);
  end

  // x & (x-1) drops the lowest set bit: the mask left after this handshake.
  assign pending_nxt = pending & (pending - N'(1));

  assign idx_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign idx_out   = idx_valid ? low_idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      done    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        // Flush wins over any same-cycle handshake or load; count is kept.
        state   <= IDLE;
        pending <= '0;
      end else begin
        case (state)
          IDLE: if (load) begin
            pending <= mask_in;
            count   <= '0;
            if (mask_in != '0) state <= SCAN;
            else               done  <= 1'b1;
          end
          SCAN: if (idx_ready) begin
            pending <= pending_nxt;
            count   <= count + (IDX_W+1)'(1);
            if (pending_nxt == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mask_index_encoder.sv
// Directed bench for mask_index_encoder; each sample packs all outputs as
// {idx_valid, busy, done, count[7:0], idx_out[6:0]}.
module tb_mask_index_encoder;

  localparam int IDX_W = 7;
  localparam int N     = 128;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [N-1:0]     mask_in;
  logic             clear;
  logic             idx_ready;
  logic [IDX_W-1:0] idx_out;
  logic             idx_valid;
  logic             busy;
  logic             done;
  logic [IDX_W:0]   count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [17:0] obs;
  assign obs = {idx_valid, busy, done, count, idx_out};

  always #5 clk = ~clk;

  mask_index_encoder #(.IDX_W(IDX_W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .mask_in(mask_in), .clear(clear),
    .idx_ready(idx_ready), .idx_out(idx_out), .idx_valid(idx_valid),
    .busy(busy), .done(done), .count(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    rst_n = 1'b0; load = 1'b0; mask_in = '0; clear = 1'b0; idx_ready = 1'b0;
    #3;
    exp = {1'b0, 1'b0, 1'b0, 8'd0, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL reset: got %h want %h", obs, exp); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (obs !== exp) $display("FAIL reset_idle: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [17:0] exp;
    mask_in = '0; mask_in[0] = 1'b1; load = 1'b1; idx_ready = 1'b1;
    step();
    load = 1'b0;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL single_idx: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b0, 1'b0, 1'b1, 8'd1, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL single_done: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b0, 1'b0, 1'b0, 8'd1, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL single_after: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_sparse();
    logic [17:0] exp;
    logic [6:0]  seq [3] = '{7'd3, 7'd64, 7'd127};
    mask_in = '0; mask_in[3] = 1'b1; mask_in[64] = 1'b1; mask_in[127] = 1'b1;
    load = 1'b1; idx_ready = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 1'b1, 1'b0, 8'(i), seq[i]};
      total_cnt++;
      if (obs !== exp) $display("FAIL sparse_%0d: got %h want %h", i, obs, exp); else pass_cnt++;
      step();
    end
    exp = {1'b0, 1'b0, 1'b1, 8'd3, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL sparse_done: got %h want %h", obs, exp); else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    logic [17:0] exp;
    logic [6:0]  seq [3] = '{7'd3, 7'd64, 7'd127};
    mask_in = '0; mask_in[3] = 1'b1; mask_in[64] = 1'b1; mask_in[127] = 1'b1;
    load = 1'b1; idx_ready = 1'b0;
    step();
    load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp = {1'b1, 1'b1, 1'b0, 8'd0, 7'd3};
      total_cnt++;
      if (obs !== exp) $display("FAIL bp_stall_%0d: got %h want %h", c, obs, exp); else pass_cnt++;
      step();
    end
    idx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 1'b1, 1'b0, 8'(i), seq[i]};
      total_cnt++;
      if (obs !== exp) $display("FAIL bp_seq_%0d: got %h want %h", i, obs, exp); else pass_cnt++;
      step();
    end
    exp = {1'b0, 1'b0, 1'b1, 8'd3, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL bp_done: got %h want %h", obs, exp); else pass_cnt++;
    step();
  endtask

  task automatic test_empty();
    logic [17:0] exp;
    mask_in = '0; load = 1'b1; idx_ready = 1'b1;
    step();
    load = 1'b0;
    exp = {1'b0, 1'b0, 1'b1, 8'd0, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL empty_done: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b0, 1'b0, 1'b0, 8'd0, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL empty_after: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_load_busy();
    logic [17:0] exp;
    mask_in = '0; mask_in[5] = 1'b1; mask_in[6] = 1'b1; load = 1'b1; idx_ready = 1'b1;
    step();
    mask_in = '0; mask_in[9] = 1'b1;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 7'd5};
    total_cnt++;
    if (obs !== exp) $display("FAIL lb_first: got %h want %h", obs, exp); else pass_cnt++;
    step();
    load = 1'b0;
    exp = {1'b1, 1'b1, 1'b0, 8'd1, 7'd6};
    total_cnt++;
    if (obs !== exp) $display("FAIL lb_second: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b0, 1'b0, 1'b1, 8'd2, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL lb_done: got %h want %h", obs, exp); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp;
    mask_in = '0; mask_in[2] = 1'b1; load = 1'b1; idx_ready = 1'b1;
    step();
    mask_in = '0; mask_in[4] = 1'b1;  // held through the completing edge: dropped
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 7'd2};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_first: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b0, 1'b0, 1'b1, 8'd1, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_done: got %h want %h", obs, exp); else pass_cnt++;
    step();
    load = 1'b0;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 7'd4};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_reload: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b0, 1'b0, 1'b1, 8'd1, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_done2: got %h want %h", obs, exp); else pass_cnt++;
    step();
  endtask

  task automatic test_clear();
    logic [17:0] exp;
    mask_in = '0; mask_in[1] = 1'b1; mask_in[2] = 1'b1; mask_in[3] = 1'b1;
    load = 1'b1; idx_ready = 1'b1;
    step();
    load = 1'b0;
    exp = {1'b1, 1'b1, 1'b0, 8'd0, 7'd1};
    total_cnt++;
    if (obs !== exp) $display("FAIL clr_first: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b1, 1'b1, 1'b0, 8'd1, 7'd2};
    total_cnt++;
    if (obs !== exp) $display("FAIL clr_second: got %h want %h", obs, exp); else pass_cnt++;
    clear = 1'b1;
    step();
    exp = {1'b0, 1'b0, 1'b0, 8'd1, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL clr_flush: got %h want %h", obs, exp); else pass_cnt++;
    load = 1'b1; mask_in = '0; mask_in[8] = 1'b1;  // clear still high: load dropped
    step();
    clear = 1'b0; load = 1'b0;
    total_cnt++;
    if (obs !== exp) $display("FAIL clr_over_load: got %h want %h", obs, exp); else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== exp) $display("FAIL clr_no_done: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp;
    mask_in = '1; load = 1'b1; idx_ready = 1'b1;
    step();
    load = 1'b0;
    step();
    exp = {1'b1, 1'b1, 1'b0, 8'd1, 7'd1};
    total_cnt++;
    if (obs !== exp) $display("FAIL rst_pre: got %h want %h", obs, exp); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 1'b0, 8'd0, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL rst_async: got %h want %h", obs, exp); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (obs !== exp) $display("FAIL rst_after: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_all_ones();
    logic [17:0] exp;
    int          errs = 0;
    mask_in = '1; load = 1'b1; idx_ready = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 128; i++) begin
      exp = {1'b1, 1'b1, 1'b0, 8'(i), 7'(i)};
      total_cnt++;
      if (obs !== exp) begin
        if (errs < 5) $display("FAIL ones_%0d: got %h want %h", i, obs, exp);
        errs++;
      end else pass_cnt++;
      step();
    end
    exp = {1'b0, 1'b0, 1'b1, 8'h80, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL ones_done: got %h want %h", obs, exp); else pass_cnt++;
    step();
    exp = {1'b0, 1'b0, 1'b0, 8'h80, 7'd0};
    total_cnt++;
    if (obs !== exp) $display("FAIL ones_single_done: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sparse();
    test_backpressure();
    test_empty();
    test_load_busy();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_all_ones();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
